stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Top-level control FSM for the bf8b multi-cycle core.
- Sequences the fetch, decode, execute and writeback stages one instruction at a time, using each stage's en/ready handshake.
- Detects halt, retires instructions, and trips a fault when a stage stalls.
- Sits between the core top level and the four stage modules; it owns every stage enable.

Parameters:
- OP_HLT, 4'b1111, opcode that halts the core after decode.
- TIMEOUT_CYCLES, 15, maximum cycles a stage may hold ready low while enabled before fault (1..255).
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = execute instructions.
- op  input  4  opcode from decode stage, valid when decode_ready=1.
- fetch_ready  input  1  fetch stage done.
- decode_ready  input  1  decode stage done.
- exec_ready  input  1  execute stage done.
- wb_ready  input  1  writeback stage done.
- fetch_en  output  1  fetch stage enable.
- decode_en  output  1  decode stage enable.
- exec_en  output  1  execute stage enable.
- wb_en  output  1  writeback stage enable.
- pc_inc  output  1  one-cycle pulse: instruction retired, advance PC.
- busy  output  1  instruction in flight.
- halted  output  1  core halted on OP_HLT.
- fault  output  1  stage timeout, sticky until reset.
- instr_count  output  COUNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, instr_count=0, timeout counter=0. Takes effect immediately, including mid-instruction; all enables drop combinationally with reset assertion.
- All outputs are registered and decoded from state. Exactly one *_en is high at a time.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED, FAULT.
- IDLE: en outputs 0, busy=0. If run=1 at the edge, go to FETCH; fetch_en=1 from that edge.
- FETCH, DECODE, EXEC, WB:
  - The matching en is held high continuously until the matching ready is sampled 1.
  - Ready inputs are ignored in all other states.
  - Stages that require en high for two consecutive cycles, such as writeback, are satisfied by this hold.
- On sampling ready=1:
  - FETCH->DECODE, DECODE->EXEC, EXEC->WB.
  - The old en drops and the next en rises on the same edge, so each stage sees en low between instructions.
- DECODE with decode_ready=1 and op==OP_HLT: go to HALTED instead of EXEC. The instruction does not retire: no pc_inc, no count.
- WB with wb_ready=1:
  - pc_inc=1 for exactly one cycle and instr_count increments, wrapping at 2^COUNT_W-1 -> 0.
  - Next state is FETCH if run=1, else IDLE.
- run=0 mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE. It never aborts.
- HALTED: halted=1, en outputs 0. Stays until run=0, then IDLE on the next edge and halted clears. run held 1 keeps it halted.
- Timeout counter:
  - Cleared on every stage-state entry.
  - Increments each cycle in FETCH, DECODE, EXEC or WB while the ready is 0.
  - When it reaches TIMEOUT_CYCLES with ready still 0, go to FAULT.
  - A ready arriving in the same cycle the count hits the limit wins: normal transition, no fault.
- FAULT: fault=1, en outputs 0, busy=0. Exits only by reset; run is ignored.
- busy=1 in FETCH, DECODE, EXEC, WB; 0 otherwise.
- Minimum instruction latency with ready returned the cycle after en: 8 cycles from FETCH entry to pc_inc.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit), placed after run.
  - After every retirement the FSM returns to IDLE regardless of run.
  - From IDLE it starts FETCH only on step=1 (run ignored in IDLE), executing exactly one instruction per step.
  - step held high longer is harmless: it is sampled only in IDLE.
  - HALTED exits when step=0 and run=0.
- Not defined: no step port; behaviour as in Behaviour.

Test Plan:
- Normal run:
  - Stimulus: run=1; each stage returns ready 1 cycle after en; OP=4'b0011.
  - Response: en sequence fetch, decode, exec, wb, one stage at a time; pc_inc pulses every 8 cycles; instr_count 0->1->2->3 after 3 instructions.
- Stalled writeback:
  - Stimulus: wb_ready delayed 5 cycles.
  - Response: wb_en held high 6 cycles continuous; no fault; single pc_inc.
- Halt:
  - Stimulus: decode returns op=4'b1111.
  - Response: HALTED, halted=1, exec_en never rises, instr_count unchanged. run=0 -> halted=0 next cycle, busy=0.
- Timeout:
  - Stimulus: exec_ready held 0.
  - Response: fault=1 after 15 cycles in EXEC, all en=0. Further readies and run ignored until rst_n pulse.
- run drop and reset:
  - Stimulus: run=0 during DECODE.
  - Response: instruction completes, one pc_inc, then IDLE.
  - Stimulus: rst_n=0 during WB.
  - Response: wb_en=0 immediately, instr_count=0, no pc_inc.
- Counter wrap:
  - Stimulus: COUNT_W=2, retire 5 instructions.
  - Response: instr_count 1,2,3,0,1.

Source files
------------

// File: rtl/stage_sequencer.sv
// Control FSM for the bf8b multi-cycle core: walks fetch/decode/execute/writeback
// via en/ready handshakes, retires, halts and faults. Optional macro: SEQ_SINGLE_STEP_EN.
module stage_sequencer #(
    parameter logic [3:0]  OP_HLT         = 4'b1111,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [3:0]         op,
    input  logic               fetch_ready,
    input  logic               decode_ready,
    input  logic               exec_ready,
    input  logic               wb_ready,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               wb_en,
    output logic               pc_inc,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state, state_nxt;
    logic [7:0] tcnt, tcnt_nxt;
    logic       stage_rdy;
    logic       retire;
    logic       start_ok;
    logic       halt_exit;
    logic       wb_continue;

`ifdef SEQ_SINGLE_STEP_EN
    assign start_ok    = step;
    assign halt_exit   = !run && !step;
    assign wb_continue = 1'b0;
`else
    assign start_ok    = run;
    assign halt_exit   = !run;
    assign wb_continue = run;
`endif

    always_comb begin
        stage_rdy = 1'b0;
        case (state)
            S_FETCH:  stage_rdy = fetch_ready;
            S_DECODE: stage_rdy = decode_ready;
            S_EXEC:   stage_rdy = exec_ready;
            S_WB:     stage_rdy = wb_ready;
            default:  stage_rdy = 1'b0;
        endcase
    end

    // A ready sampled on the limit cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        retire    = 1'b0;
        case (state)
            S_IDLE: begin
                tcnt_nxt = '0;
                if (start_ok) state_nxt = S_FETCH;
            end
            S_FETCH, S_DECODE, S_EXEC, S_WB: begin
                if (stage_rdy) begin
                    tcnt_nxt = '0;
                    case (state)
                        S_FETCH:  state_nxt = S_DECODE;
                        S_DECODE: state_nxt = (op == OP_HLT) ? S_HALTED : S_EXEC;
                        S_EXEC:   state_nxt = S_WB;
                        default: begin
                            retire    = 1'b1;
                            state_nxt = wb_continue ? S_FETCH : S_IDLE;
                        end
                    endcase
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end
            S_HALTED: begin
                if (halt_exit) state_nxt = S_IDLE;
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            pc_inc      <= 1'b0;
            instr_count <= '0;
        end else begin
            state  <= state_nxt;
            tcnt   <= tcnt_nxt;
            pc_inc <= retire;
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

    // Straight decodes of the state register, so async reset clears them at once.
    assign fetch_en  = (state == S_FETCH);
    assign decode_en = (state == S_DECODE);
    assign exec_en   = (state == S_EXEC);
    assign wb_en     = (state == S_WB);
    assign busy      = fetch_en | decode_en | exec_en | wb_en;
    assign halted    = (state == S_HALTED);
    assign fault     = (state == S_FAULT);

endmodule
